// File: rtl/sdspi_perf_monitor_if.sv
// sdspi_perf_monitor_if: UUT observation and result handshake bundle for the perf monitor
// Observed UUT signals:
//   uut_start     UUT start strobe/level
//   uut_finish    UUT finish level
//   uut_n_blocks  block count applied to the UUT
//   sclk_uut      UUT SCLK (clk domain)
//   cs_uut        UUT chip select, active-low
// Result handshake:
//   busy          high while a run is being measured
//   result_valid  results stable and available
//   result_ready  consumer accepts the results
//   cycle_count   clk cycles of the run
//   sclk_count    qualifying SCLK rising edges (saturating)
//   blocks        block count latched at run start
//   timeout       run aborted by timeout
//   overflow      sclk_count saturated
interface sdspi_perf_monitor_if #(
    parameter int CNT_WIDTH    = 32,
    parameter int N_BLOCK_SIZE = 32
);
    logic                    uut_start;
    logic                    uut_finish;
    logic [N_BLOCK_SIZE-1:0] uut_n_blocks;
    logic                    sclk_uut;
    logic                    cs_uut;
    logic                    busy;
    logic                    result_valid;
    logic                    result_ready;
    logic [CNT_WIDTH-1:0]    cycle_count;
    logic [CNT_WIDTH-1:0]    sclk_count;
    logic [N_BLOCK_SIZE-1:0] blocks;
    logic                    timeout;
    logic                    overflow;
    modport master (
        output uut_start, uut_finish, uut_n_blocks, sclk_uut, cs_uut, result_ready,
        input  busy, result_valid, cycle_count, sclk_count, blocks, timeout, overflow
    );
    modport slave (
        input  uut_start, uut_finish, uut_n_blocks, sclk_uut, cs_uut, result_ready,
        output busy, result_valid, cycle_count, sclk_count, blocks, timeout, overflow
    );
endinterface

// File: rtl/sdspi_perf_monitor.sv
// sdspi_perf_monitor: measures cycles and SCLK edges of one sdspi_system run, with timeout
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset; a run in progress is discarded
//   bus      sdspi_perf_monitor_if.slave: UUT observation inputs and result handshake
module sdspi_perf_monitor #(
    parameter int CNT_WIDTH      = 32,
    parameter int N_BLOCK_SIZE   = 32,
    parameter int TIMEOUT_CYCLES = 500000000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    sdspi_perf_monitor_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    // Compare at no less than 32 bits so the timeout constant is never truncated
    localparam int CMP_W = (CNT_WIDTH > 32) ? CNT_WIDTH : 32;
    localparam logic [CMP_W-1:0] TO_LAST = CMP_W'(TIMEOUT_CYCLES - 1);
    state_t                  r_state;
    logic                    r_start_q, r_finish_q, r_sclk_q;
    logic [CNT_WIDTH-1:0]    r_cycle, r_sclk;
    logic [N_BLOCK_SIZE-1:0] r_blocks;
    logic                    r_timeout, r_overflow, r_valid, r_busy;
    logic                    w_start_rise, w_finish_rise, w_sclk_hit, w_to_hit;
    logic [CNT_WIDTH-1:0]    w_sclk_next;
    assign w_start_rise  = bus.uut_start & ~r_start_q;
    assign w_finish_rise = bus.uut_finish & ~r_finish_q;
    assign w_sclk_hit    = bus.sclk_uut & ~r_sclk_q & ~bus.cs_uut;
    assign w_to_hit      = CMP_W'(r_cycle) == TO_LAST;
    assign w_sclk_next   = r_sclk + 1'b1;
    assign bus.busy         = r_busy;
    assign bus.result_valid = r_valid;
    assign bus.cycle_count  = r_cycle;
    assign bus.sclk_count   = r_sclk;
    assign bus.blocks       = r_blocks;
    assign bus.timeout      = r_timeout;
    assign bus.overflow     = r_overflow;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_start_q  <= 1'b0;
            r_finish_q <= 1'b0;
            r_sclk_q   <= 1'b0;
            r_cycle    <= '0;
            r_sclk     <= '0;
            r_blocks   <= '0;
            r_timeout  <= 1'b0;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_start_q  <= bus.uut_start;
            r_finish_q <= bus.uut_finish;
            r_sclk_q   <= bus.sclk_uut;
            case (r_state)
                S_IDLE: if (w_start_rise) begin
                    r_state    <= S_RUN;
                    r_busy     <= 1'b1;
                    r_cycle    <= '0;
                    r_sclk     <= '0;
                    r_timeout  <= 1'b0;
                    r_overflow <= 1'b0;
                    r_blocks   <= bus.uut_n_blocks;
                end
                S_RUN: begin
                    // Edges still count on the closing edge; only the cycle count skips it
                    if (w_sclk_hit && !(&r_sclk)) begin
                        r_sclk <= w_sclk_next;
                        if (&w_sclk_next) r_overflow <= 1'b1;
                    end
                    if (w_finish_rise) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b1;
                    end else begin
                        r_cycle <= r_cycle + 1'b1;
                        if (w_to_hit) begin
                            r_timeout <= 1'b1;
                            r_state   <= S_DONE;
                            r_busy    <= 1'b0;
                            r_valid   <= 1'b1;
                        end
                    end
                end
                S_DONE: if (bus.result_ready) begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/sdspi_perf_monitor.md
Name: sdspi_perf_monitor

Overview:
- Measurement stage directly downstream of sdspi_system in the hardware-performance build.
- Watches the UUT start/finish handshake and its SPI pins, and counts system-clock cycles and SCLK transfer edges for one run.
- Returns the results to the autotest sequencer and debug display through a valid/ready result handshake.
- Detects hung runs by timeout, so the autotest flow never stalls.

Parameters:
- CNT_WIDTH, 32: width of the cycle and SCLK-edge counters.
- N_BLOCK_SIZE, 32: width of the latched block-count field.
- TIMEOUT_CYCLES, 500000000: RUN cycles before a forced abort (5 s at 100 MHz). Must be less than 2^CNT_WIDTH.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  reset, asynchronous, active-low
- uut_start  in  1  UUT start strobe/level, same signal driven to sdspi_system
- uut_finish  in  1  UUT finish level from sdspi_system
- uut_n_blocks  in  N_BLOCK_SIZE  block count applied to the UUT for this run
- sclk_uut  in  1  UUT SCLK, generated in the clk domain
- cs_uut  in  1  UUT chip select, active-low
- busy  out  1  high while in RUN
- result_valid  out  1  results stable and available
- result_ready  in  1  consumer accepts the results
- cycle_count  out  CNT_WIDTH  clk cycles measured for the run
- sclk_count  out  CNT_WIDTH  SCLK rising edges seen with cs_uut low
- blocks  out  N_BLOCK_SIZE  uut_n_blocks latched at run start
- timeout  out  1  run aborted by timeout
- overflow  out  1  sclk_count saturated

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs and counters clear to 0.
  - Edge-detect registers start_q, finish_q and sclk_q clear to 0.
  - Reset mid-run discards the run with no result.
- Edge-detect registers:
  - start_q, finish_q and sclk_q update every cycle in every state.
  - start_rise = uut_start & ~start_q. finish_rise and sclk_rise are formed the same way.
  - Inputs are in the clk domain, so there is no synchroniser.
- IDLE:
  - On start_rise, go to RUN next cycle.
  - On that same edge: cycle_count=0, sclk_count=0, timeout=0, overflow=0, blocks=uut_n_blocks.
  - Otherwise hold the previous results unchanged.
- RUN (busy=1):
  - Each edge without finish_rise: cycle_count += 1.
  - Each edge with sclk_rise & ~cs_uut: sclk_count += 1, saturating at all-ones; on saturation set overflow=1 (sticky).
  - finish_rise: go to DONE and do not increment cycle_count on that edge.
  - A start pulse 1 cycle wide sampled at edge k, with finish rising at edge k+1+N, therefore gives cycle_count=N.
  - Timeout: when cycle_count==TIMEOUT_CYCLES-1 and there is no finish_rise, take the increment, set timeout=1 and go to DONE.
  - finish_rise on that same edge has priority: timeout stays 0.
  - A finish level already high when RUN is entered does not end the run; a fresh rising edge is required.
  - start_rise during RUN is ignored.
- DONE:
  - result_valid=1; all result outputs are held stable.
  - When result_valid & result_ready is sampled, clear result_valid and go to IDLE next cycle.
  - start_rise in DONE is ignored; results must be consumed first.
  - result_ready is a don't-care outside DONE.
- Latency: result_valid rises 1 cycle after the finish_rise or timeout edge.

Test Plan:
- Reset, 1-cycle start, uut_finish rising 100 edges later -> result_valid at the next cycle; cycle_count=100, timeout=0, busy low in DONE.
- uut_n_blocks=5 at start, changed to 9 mid-run -> blocks=5.
- In RUN, sclk toggled every 2 cycles for 64 rising edges with cs_uut low, plus 16 edges with cs_uut high -> sclk_count=64, overflow=0.
- TIMEOUT_CYCLES=50, finish never rises -> DONE after 50 RUN cycles; cycle_count=50, timeout=1. Second run, finish_rise coinciding with cycle_count==49 -> timeout=0, cycle_count=49.
- result_ready held low 10 cycles in DONE -> results stable and a start_rise ignored; ready=1 -> IDLE. Second start with uut_finish still high from the previous run -> no premature DONE until a new finish rising edge.
- rst driven low mid-RUN, asynchronously between clk edges -> all outputs 0 immediately, state IDLE. CNT_WIDTH=4 with 20 qualifying SCLK edges -> sclk_count=15, overflow=1.
